tcbm_reg_fifo: RTL and testbench

- Parametrised successor to the single enabled register: a DEPTH-entry, WIDTH-bit first-word-fall-through buffer with a programmable empty value.
- Sits between the TCBM bus-side strobe logic (the writer) and the drive/SD controller side (the reader).
- Absorbs bursts of command and data bytes so neither side stalls on single-cycle latch timing.
- Provides occupancy and error flags.

---
 rtl/tcbm_defs.sv | 22 ++
 rtl/tcbm_fifo_ptr.sv | 24 ++
 rtl/tcbm_reg_fifo.sv | 106 ++++++++++
 tb/tb_tcbm_reg_fifo.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/tcbm_defs.sv
// Shared constants for the tcbm_* blocks: default data width, default empty
// value, the bus byte width, and a constant clog2 helper for pointer sizing.
package tcbm_defs;

    localparam int DEFAULT_WIDTH  = 8;
    localparam int DEFAULT_RESET  = 0;
    localparam int BUS_BYTE_WIDTH = 8;

    // Ceiling log2, used at elaboration time to size pointers.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/tcbm_fifo_ptr.sv
// AW-bit wrapping pointer with increment enable and synchronous clear.
// Wrap from DEPTH-1 back to 0 comes for free because DEPTH is a power of two.
module tcbm_fifo_ptr #(
    parameter int AW = 2
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clear,
    input  logic          inc,
    output logic [AW-1:0] ptr
);

    // Pointer register: async reset, then clear has priority over increment.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (clear) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + 1'b1;
        end
    end

endmodule

// File: rtl/tcbm_reg_fifo.sv
// DEPTH-entry, WIDTH-bit first-word-fall-through buffer between the TCBM
// bus-side strobe logic (writer) and the drive/SD controller side (reader).
// q shows RESET while empty. Occupancy, overflow and underflow flags provided.
// Build option: TCBM_REG_FIFO_STICKY_EN makes overflow/underflow sticky until
// flush or reset; otherwise they are one-cycle pulses.
module tcbm_reg_fifo
    import tcbm_defs::*;
#(
    parameter int              WIDTH = DEFAULT_WIDTH,
    parameter int              DEPTH = 4,
    parameter logic [WIDTH-1:0] RESET = WIDTH'(DEFAULT_RESET),
    localparam int             AW    = clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] d,
    input  logic             rd_en,
    output logic [WIDTH-1:0] q,
    output logic             empty,
    output logic             full,
    output logic [AW:0]      count,
    output logic             overflow,
    output logic             underflow
);

    logic [WIDTH-1:0] storage [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_accept;
    logic             rd_accept;
    logic             wr_drop;
    logic             rd_ignore;

    // Accept/drop decisions; a simultaneous read frees the slot at full.
    always_comb begin
        wr_accept = wr_en && (!full || rd_en);
        rd_accept = rd_en && !empty;
        wr_drop   = wr_en && full && !rd_en;
        rd_ignore = rd_en && empty;
    end

    // Status and head data are derived purely from registered state.
    always_comb begin
        empty = (count == '0);
        full  = (count == (AW + 1)'(DEPTH));
        q     = empty ? RESET : storage[rd_ptr];
    end

    tcbm_fifo_ptr #(.AW(AW)) u_wr_ptr (
        .clock (clock),
        .reset (reset),
        .clear (flush),
        .inc   (wr_accept),
        .ptr   (wr_ptr)
    );

    tcbm_fifo_ptr #(.AW(AW)) u_rd_ptr (
        .clock (clock),
        .reset (reset),
        .clear (flush),
        .inc   (rd_accept),
        .ptr   (rd_ptr)
    );

    // Storage is not reset; stale contents are hidden behind empty.
    always_ff @(posedge clock) begin
        if (!flush && wr_accept) begin
            storage[wr_ptr] <= d;
        end
    end

    // Occupancy: up on write only, down on read only.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else if (wr_accept && !rd_accept) begin
            count <= count + 1'b1;
        end else if (rd_accept && !wr_accept) begin
            count <= count - 1'b1;
        end
    end

    // Error flags: pulse or sticky depending on the build.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
`ifdef TCBM_REG_FIFO_STICKY_EN
            overflow  <= overflow | wr_drop;
            underflow <= underflow | rd_ignore;
`else
            overflow  <= wr_drop;
            underflow <= rd_ignore;
`endif
        end
    end

endmodule

// File: tb/tb_tcbm_reg_fifo.sv
// Self-checking bench for tcbm_reg_fifo (DEPTH=4, WIDTH=8, RESET=0xE7).
// A queue model is compared against the DUT every cycle on the falling edge;
// directed steps add hand-computed literal checks.
module tb_tcbm_reg_fifo;

    localparam int         WIDTH = 8;
    localparam int         DEPTH = 4;
    localparam logic [7:0] RVAL  = 8'hE7;

    logic       clock;
    logic       reset;
    logic       flush;
    logic       wr_en;
    logic [7:0] d;
    logic       rd_en;
    logic [7:0] q;
    logic       empty;
    logic       full;
    logic [2:0] count;
    logic       overflow;
    logic       underflow;

    int checks_total;
    int checks_passed;
    bit compare_on;

    logic [7:0] mq[$];
    logic       m_ovf;
    logic       m_udf;

    tcbm_reg_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET(RVAL)) dut (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .wr_en     (wr_en),
        .d         (d),
        .rd_en     (rd_en),
        .q         (q),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    // Free-running clock, period 10.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks_total++;
        if (act !== exp) begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end else begin
            checks_passed++;
        end
    endtask

    // Drive one cycle of inputs, wait past the edge, then return to idle.
    task automatic applyStimulus(input logic w, input logic [7:0] dv, input logic r, input logic f);
        wr_en = w;
        d     = dv;
        rd_en = r;
        flush = f;
        @(posedge clock);
        #1;
        wr_en = 1'b0;
        d     = 8'h00;
        rd_en = 1'b0;
        flush = 1'b0;
    endtask

    // Behavioural model: a queue plus two flags, evaluated from pre-edge state.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            mq.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else if (flush) begin
            mq.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            int  sz;
            bit  ovf_e;
            bit  udf_e;
            sz    = mq.size();
            ovf_e = wr_en && (sz == DEPTH) && !rd_en;
            udf_e = rd_en && (sz == 0);
            if (rd_en && sz > 0) void'(mq.pop_front());
            if (wr_en && (sz < DEPTH || rd_en)) mq.push_back(d);
`ifdef TCBM_REG_FIFO_STICKY_EN
            m_ovf = m_ovf | ovf_e;
            m_udf = m_udf | udf_e;
`else
            m_ovf = ovf_e;
            m_udf = udf_e;
`endif
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clock) begin
        if (compare_on) begin
            logic [7:0] exp_q;
            exp_q = (mq.size() > 0) ? mq[0] : RVAL;
            checkOutput("model_q", 32'(q), 32'(exp_q));
            checkOutput("model_count", 32'(count), 32'(mq.size()));
            checkOutput("model_empty", 32'(empty), 32'(mq.size() == 0));
            checkOutput("model_full", 32'(full), 32'(mq.size() == DEPTH));
            checkOutput("model_overflow", 32'(overflow), 32'(m_ovf));
            checkOutput("model_underflow", 32'(underflow), 32'(m_udf));
        end
    end

    initial begin
        logic [7:0] seq_a [4];
        logic [7:0] seq_b [4];
        seq_a = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        seq_b = '{8'hA1, 8'hA2, 8'hA3, 8'hB4};
        checks_total  = 0;
        checks_passed = 0;
        compare_on    = 1'b0;
        reset = 1'b1;
        flush = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        d     = 8'h00;
        #2;
        checkOutput("reset_q", 32'(q), 32'hE7);
        checkOutput("reset_empty", 32'(empty), 32'd1);
        checkOutput("reset_count", 32'(count), 32'd0);
        checkOutput("reset_full", 32'(full), 32'd0);
        #10;
        reset = 1'b0;
        compare_on = 1'b1;

        // Reset mid-burst.
        applyStimulus(1'b1, 8'h11, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h22, 1'b0, 1'b0);
        checkOutput("burst_count", 32'(count), 32'd2);
        checkOutput("burst_q", 32'(q), 32'h11);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("async_reset_q", 32'(q), 32'hE7);
        checkOutput("async_reset_count", 32'(count), 32'd0);
        checkOutput("async_reset_empty", 32'(empty), 32'd1);
        checkOutput("async_reset_flags", 32'({overflow, underflow}), 32'd0);
        reset = 1'b0;
        @(posedge clock);
        #1;

        // Fill to full, then overflow attempt.
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, seq_a[i], 1'b0, 1'b0);
        checkOutput("fill_full", 32'(full), 32'd1);
        checkOutput("fill_count", 32'(count), 32'd4);
        applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0);
        checkOutput("ovf_pulse", 32'(overflow), 32'd1);
        checkOutput("ovf_count", 32'(count), 32'd4);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
`ifdef TCBM_REG_FIFO_STICKY_EN
        checkOutput("ovf_after", 32'(overflow), 32'd1);
`else
        checkOutput("ovf_after", 32'(overflow), 32'd0);
`endif

        // Drain: A0..A3 with the dropped 0xFF never appearing.
        for (int i = 0; i < 4; i++) begin
            checkOutput("drain_a_q", 32'(q), 32'(seq_a[i]));
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        end
        checkOutput("drain_a_empty", 32'(empty), 32'd1);
        checkOutput("drain_a_q_reset", 32'(q), 32'hE7);

        // Simultaneous read/write at full, then drain through the wrap.
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, seq_a[i], 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hB4, 1'b1, 1'b0);
        checkOutput("simul_count", 32'(count), 32'd4);
        checkOutput("simul_q", 32'(q), 32'hA1);
        for (int i = 0; i < 4; i++) begin
            checkOutput("drain_b_q", 32'(q), 32'(seq_b[i]));
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        end
        checkOutput("drain_b_empty", 32'(empty), 32'd1);

        // Underflow together with a write that still lands.
        applyStimulus(1'b1, 8'h5C, 1'b1, 1'b0);
        checkOutput("udf_flag", 32'(underflow), 32'd1);
        checkOutput("udf_count", 32'(count), 32'd1);
        checkOutput("udf_q", 32'(q), 32'h5C);

        // Flush beats a concurrent write.
        applyStimulus(1'b1, 8'h66, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h67, 1'b0, 1'b0);
        checkOutput("pre_flush_count", 32'(count), 32'd3);
        applyStimulus(1'b1, 8'h77, 1'b0, 1'b1);
        checkOutput("flush_count", 32'(count), 32'd0);
        checkOutput("flush_empty", 32'(empty), 32'd1);
        checkOutput("flush_q", 32'(q), 32'hE7);
        checkOutput("flush_flags", 32'({overflow, underflow}), 32'd0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("post_flush_count", 32'(count), 32'd0);

        @(negedge clock);
        compare_on = 1'b0;
        #1;
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
